trig_pulse_gen: RTL and testbench

//  Downstream stage of the trigger qualification filter. Takes the filtered trigger level (TRIG)
//  and detects its rising edge. Emits one gate pulse (GATE) per accepted trigger, with

---
 rtl/trig_pulse_gen_pkg.sv | 27 ++
 rtl/trig_pulse_gen_downcnt.sv | 33 +++
 rtl/trig_pulse_gen.sv | 194 +++++++++++++++++++
 tb/tb_trig_pulse_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pulse_gen_pkg.sv
// Shared types and constants for the trigger pulse generator.
// Holds the FSM encoding, default field width and the miss-counter helper.
package trig_pulse_gen_pkg;

   localparam int TPG_CW  = 16;
   localparam int MISS_CW = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DELAY = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } tpg_state_t;

   // Saturating increment; the miss counter sticks at all-ones.
   function automatic logic [MISS_CW-1:0] miss_sat_inc(input logic [MISS_CW-1:0] v);
      logic [MISS_CW-1:0] r;
      if (v == {MISS_CW{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(MISS_CW-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/trig_pulse_gen_downcnt.sv
// Loadable down-counter shared by the DELAY, PULSE and HOLD phases.
// Load has priority over decrement; is_one flags the last clock of a phase.
module trig_pulse_gen_downcnt #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic          is_one
);

   localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt_r;

   // Counter register: load a new phase length or count down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec) begin
         cnt_r <= cnt_r - ONE_CW;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign is_one = (cnt_r == ONE_CW);

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger pulse generator: rising-edge detect on TRIG, delay/width/holdoff gate FSM,
// accepted-trigger counter and missed-trigger tracking.
module trig_pulse_gen
   import trig_pulse_gen_pkg::*;
#(
   parameter int CW = TPG_CW
) (
   input  logic               C,
   input  logic               RN,
   input  logic               TRIG,
   input  logic               EN,
   input  logic               ONESHOT,
   input  logic [CW-1:0]      DLY,
   input  logic [CW-1:0]      WID,
   input  logic [CW-1:0]      HLD,
   input  logic               CLR,
   output logic               GATE,
   output logic               BUSY,
   output logic [CW-1:0]      TRIG_CNT,
   output logic               MISS,
   output logic [MISS_CW-1:0] MISS_CNT
);

   localparam logic [CW-1:0]      ZERO_CW = {CW{1'b0}};
   localparam logic [CW-1:0]      ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [MISS_CW-1:0] ZERO_M  = {MISS_CW{1'b0}};
   localparam logic [MISS_CW-1:0] ONE_M   = {{(MISS_CW-1){1'b0}}, 1'b1};

   function automatic logic [CW-1:0] wid_eff(input logic [CW-1:0] w);
      logic [CW-1:0] r;
      if (w == ZERO_CW) begin
         r = ONE_CW;
      end else begin
         r = w;
      end
      return r;
   endfunction

   tpg_state_t          state_r, state_s, exit_state_s;
   logic                trig_d_r;
   logic                rise_s, accept_s, miss_s;
   logic [CW-1:0]       wid_r, hld_r;
   logic                cnt_load_s, cnt_dec_s, cnt_one_s;
   logic [CW-1:0]       cnt_val_s;
   logic                gate_r, busy_r, miss_r;
   logic [CW-1:0]       trig_cnt_r;
   logic [MISS_CW-1:0]  miss_cnt_r;

   // trig_d resets low so a TRIG already high at reset release counts as a rise.
   assign rise_s       = TRIG & ~trig_d_r;
   assign accept_s     = EN & rise_s & (state_r == ST_IDLE);
   assign miss_s       = EN & rise_s & (state_r != ST_IDLE);
   assign exit_state_s = ONESHOT ? ST_DONE : ST_IDLE;

   trig_pulse_gen_downcnt #(.CW(CW)) u_cnt (
      .clk      (C),
      .rst_n    (RN),
      .load     (cnt_load_s),
      .dec      (cnt_dec_s),
      .load_val (cnt_val_s),
      .is_one   (cnt_one_s)
   );

   // Next-state and phase-counter control.
   always_comb begin
      state_s    = state_r;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      cnt_val_s  = ZERO_CW;
      if (!EN) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  cnt_load_s = 1'b1;
                  if (DLY == ZERO_CW) begin
                     state_s   = ST_PULSE;
                     cnt_val_s = wid_eff(WID);
                  end else begin
                     state_s   = ST_DELAY;
                     cnt_val_s = DLY;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_DELAY: begin
               if (cnt_one_s) begin
                  state_s    = ST_PULSE;
                  cnt_load_s = 1'b1;
                  cnt_val_s  = wid_r;
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_PULSE: begin
               if (cnt_one_s) begin
                  if (hld_r != ZERO_CW) begin
                     state_s    = ST_HOLD;
                     cnt_load_s = 1'b1;
                     cnt_val_s  = hld_r;
                  end else begin
                     state_s = exit_state_s;
                  end
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt_one_s) begin
                  state_s = exit_state_s;
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, edge history and working copies of the width/holdoff fields.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state_r  <= ST_IDLE;
         trig_d_r <= 1'b0;
         wid_r    <= ONE_CW;
         hld_r    <= ZERO_CW;
      end else begin
         state_r  <= state_s;
         trig_d_r <= TRIG;
         if (accept_s) begin
            wid_r <= wid_eff(WID);
            hld_r <= HLD;
         end else begin
            wid_r <= wid_r;
            hld_r <= hld_r;
         end
      end
   end

   // Registered GATE/BUSY; EN low kills the gate on the same edge that aborts the cycle.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         gate_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         gate_r <= EN & (state_r == ST_PULSE);
         busy_r <= (state_r != ST_IDLE);
      end
   end

   // Accepted-trigger counter; CLR with a coincident accept leaves it at one.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         trig_cnt_r <= ZERO_CW;
      end else if (CLR) begin
         trig_cnt_r <= accept_s ? ONE_CW : ZERO_CW;
      end else if (accept_s) begin
         trig_cnt_r <= trig_cnt_r + ONE_CW;
      end else begin
         trig_cnt_r <= trig_cnt_r;
      end
   end

   // Sticky miss flag and saturating miss counter.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         miss_r     <= 1'b0;
         miss_cnt_r <= ZERO_M;
      end else if (CLR) begin
         miss_r     <= miss_s;
         miss_cnt_r <= miss_s ? ONE_M : ZERO_M;
      end else if (miss_s) begin
         miss_r     <= 1'b1;
         miss_cnt_r <= miss_sat_inc(miss_cnt_r);
      end else begin
         miss_r     <= miss_r;
         miss_cnt_r <= miss_cnt_r;
      end
   end

   assign GATE     = gate_r;
   assign BUSY     = busy_r;
   assign TRIG_CNT = trig_cnt_r;
   assign MISS     = miss_r;
   assign MISS_CNT = miss_cnt_r;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed self-checking bench for trig_pulse_gen; a second 4-bit instance covers
// counter wrap and the all-ones delay boundary in a short run.
module tb_trig_pulse_gen;

   logic        clk, rn, trig, en, oneshot, clr;
   logic [15:0] dly, wid, hld;
   logic        gate, busy, miss;
   logic [15:0] trig_cnt;
   logic [7:0]  miss_cnt;
   logic        s_gate, s_busy, s_miss;
   logic [3:0]  s_trig_cnt;
   logic [7:0]  s_miss_cnt;
   int          checks = 0;
   int          errors = 0;

   trig_pulse_gen #(.CW(16)) u_dut (
      .C(clk), .RN(rn), .TRIG(trig), .EN(en), .ONESHOT(oneshot),
      .DLY(dly), .WID(wid), .HLD(hld), .CLR(clr),
      .GATE(gate), .BUSY(busy), .TRIG_CNT(trig_cnt), .MISS(miss), .MISS_CNT(miss_cnt)
   );

   trig_pulse_gen #(.CW(4)) u_dut_small (
      .C(clk), .RN(rn), .TRIG(trig), .EN(en), .ONESHOT(oneshot),
      .DLY(dly[3:0]), .WID(wid[3:0]), .HLD(hld[3:0]), .CLR(clr),
      .GATE(s_gate), .BUSY(s_busy), .TRIG_CNT(s_trig_cnt), .MISS(s_miss), .MISS_CNT(s_miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rn = 1'b0; trig = 1'b0; en = 1'b1; oneshot = 1'b0; clr = 1'b0;
      dly = 16'd0; wid = 16'd0; hld = 16'd0;
      repeat (2) @(posedge clk);
      #1 rn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(posedge clk); #1;
      checks++;
      if ({gate, busy, trig_cnt, miss, miss_cnt} !== 27'd0) begin
         errors++;
         $display("FAIL reset_state got g=%b b=%b tc=%0d m=%b mc=%0d want all 0", gate, busy, trig_cnt, miss, miss_cnt);
      end
   endtask

   // Rise at j=0 (DLY=3 WID=5 HLD=4), missed rise at j=6, accepted rise at j=14.
   task automatic test_basic_miss();
      logic eg, eb;
      do_reset();
      dly = 16'd3; wid = 16'd5; hld = 16'd4;
      for (int j = 0; j <= 30; j++) begin
         trig = (j <= 2) || (j >= 6 && j <= 8) || (j >= 14 && j <= 16);
         @(posedge clk); #1;
         eg = (j >= 4 && j <= 8) || (j >= 18 && j <= 22);
         eb = (j >= 1 && j <= 12) || (j >= 15 && j <= 26);
         checks++;
         if (gate !== eg) begin errors++; $display("FAIL basic_gate j=%0d got %b want %b", j, gate, eg); end
         checks++;
         if (busy !== eb) begin errors++; $display("FAIL basic_busy j=%0d got %b want %b", j, busy, eb); end
         if (j == 13) begin
            checks++;
            if (trig_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt1 got %0d want 1", trig_cnt); end
         end
      end
      checks++;
      if (trig_cnt !== 16'd2 || miss !== 1'b1 || miss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL basic_counts got tc=%0d m=%b mc=%0d want 2 1 1", trig_cnt, miss, miss_cnt);
      end
   endtask

   task automatic test_zero_fields();
      logic eg;
      do_reset();
      for (int j = 0; j <= 6; j++) begin
         trig = (j <= 3);
         @(posedge clk); #1;
         eg = (j == 1);
         checks++;
         if (gate !== eg) begin errors++; $display("FAIL zero_gate j=%0d got %b want %b", j, gate, eg); end
      end
      checks++;
      if (trig_cnt !== 16'd1) begin errors++; $display("FAIL zero_cnt got %0d want 1", trig_cnt); end
   endtask

   task automatic test_oneshot();
      logic eg;
      do_reset();
      oneshot = 1'b1; dly = 16'd2; wid = 16'd3; hld = 16'd2;
      for (int j = 0; j <= 56; j++) begin
         trig = (j <= 1) || (j == 40) || (j == 41) || (j == 50) || (j == 51);
         en   = (j != 46);
         @(posedge clk); #1;
         eg = (j >= 3 && j <= 5) || (j >= 53 && j <= 55);
         checks++;
         if (gate !== eg) begin errors++; $display("FAIL oneshot_gate j=%0d got %b want %b", j, gate, eg); end
         if (j == 44) begin
            checks++;
            if (busy !== 1'b1 || miss_cnt !== 8'd1) begin
               errors++; $display("FAIL oneshot_done got b=%b mc=%0d want 1 1", busy, miss_cnt);
            end
         end
      end
      checks++;
      if (trig_cnt !== 16'd2 || miss_cnt !== 8'd1) begin
         errors++; $display("FAIL oneshot_counts got tc=%0d mc=%0d want 2 1", trig_cnt, miss_cnt);
      end
   endtask

   task automatic test_abort();
      logic eg;
      do_reset();
      dly = 16'd1; wid = 16'd6; hld = 16'd3;
      for (int j = 0; j <= 16; j++) begin
         trig = (j <= 1) || (j == 8) || (j == 9);
         en   = !(j == 4 || j == 5);
         @(posedge clk); #1;
         eg = (j == 2) || (j == 3) || (j >= 10 && j <= 15);
         checks++;
         if (gate !== eg) begin errors++; $display("FAIL abort_gate j=%0d got %b want %b", j, gate, eg); end
         if (j == 6) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got b=%b want 0", busy); end
         end
      end
      checks++;
      if (trig_cnt !== 16'd2 || miss !== 1'b0) begin
         errors++; $display("FAIL abort_counts got tc=%0d m=%b want 2 0", trig_cnt, miss);
      end
      // Reset asserted mid-DELAY.
      do_reset();
      dly = 16'd10; wid = 16'd2;
      trig = 1'b1;
      repeat (4) @(posedge clk);
      #1 rn = 1'b0;
      #1;
      checks++;
      if ({gate, busy, trig_cnt, miss, miss_cnt} !== 27'd0) begin
         errors++; $display("FAIL rst_delay got b=%b tc=%0d want 0 0", busy, trig_cnt);
      end
      // Reset asserted mid-PULSE drops GATE without a clock.
      do_reset();
      wid = 16'd10; trig = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (gate !== 1'b1) begin errors++; $display("FAIL rst_pulse_pre got %b want 1", gate); end
      rn = 1'b0;
      #1;
      checks++;
      if (gate !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_pulse got g=%b b=%b want 0 0", gate, busy);
      end
   endtask

   task automatic test_clear_sat();
      do_reset();
      for (int j = 0; j <= 7; j++) begin
         trig = (j % 2 == 0) && (j <= 6);
         clr  = (j == 6);
         @(posedge clk); #1;
         if (j == 5) begin
            checks++;
            if (trig_cnt !== 16'd3) begin errors++; $display("FAIL clr_pre got %0d want 3", trig_cnt); end
         end
      end
      checks++;
      if (trig_cnt !== 16'd1) begin errors++; $display("FAIL clr_accept got %0d want 1", trig_cnt); end
      // One pulse into DONE, then 300 missed rises.
      do_reset();
      oneshot = 1'b1;
      for (int j = 0; j <= 601; j++) begin
         trig = (j % 2 == 0) && (j <= 600);
         @(posedge clk); #1;
      end
      checks++;
      if (miss_cnt !== 8'd255 || miss !== 1'b1 || busy !== 1'b1 || trig_cnt !== 16'd1) begin
         errors++; $display("FAIL miss_sat got mc=%0d m=%b b=%b tc=%0d want 255 1 1 1", miss_cnt, miss, busy, trig_cnt);
      end
      trig = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (miss_cnt !== 8'd1 || miss !== 1'b1) begin
         errors++; $display("FAIL clr_miss got mc=%0d m=%b want 1 1", miss_cnt, miss);
      end
      trig = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0;
      checks++;
      if (miss_cnt !== 8'd0 || miss !== 1'b0 || trig_cnt !== 16'd0) begin
         errors++; $display("FAIL clr_plain got mc=%0d m=%b tc=%0d want 0 0 0", miss_cnt, miss, trig_cnt);
      end
   endtask

   task automatic test_wrap_maxdly();
      logic eg;
      do_reset();
      for (int j = 0; j <= 31; j++) begin
         trig = (j % 2 == 0) && (j <= 30);
         @(posedge clk); #1;
         if (j == 29) begin
            checks++;
            if (s_trig_cnt !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d want 15", s_trig_cnt); end
         end
      end
      checks++;
      if (s_trig_cnt !== 4'd0 || trig_cnt !== 16'd16) begin
         errors++; $display("FAIL wrap got small=%0d main=%0d want 0 16", s_trig_cnt, trig_cnt);
      end
      do_reset();
      dly = 16'd15; wid = 16'd1;
      for (int j = 0; j <= 18; j++) begin
         trig = (j <= 1);
         @(posedge clk); #1;
         eg = (j == 16);
         checks++;
         if (s_gate !== eg) begin errors++; $display("FAIL maxdly_gate j=%0d got %b want %b", j, s_gate, eg); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_miss();
      test_zero_fields();
      test_oneshot();
      test_abort();
      test_clear_sat();
      test_wrap_maxdly();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
